dmem_arbiter: RTL and testbench

- Shares one single-port data memory (`data_mem`) between two pipeline cores, requester 0 and requester 1.
- Each requester uses a valid/ready request channel and gets a one-cycle response pulse.
- Requesters are served one transaction at a time, selected by round-robin on contention.
- Sits between each core's Memory stage and `data_mem`. Any core that uses it stalls its own pipeline until the response arrives.

---
 rtl/types_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr.sv | 31 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the data-memory arbiter: FSM states, request record and sizes.
package types_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int NUM_DMEM_REQ = 2;

  typedef logic [XLEN_DEFAULT-1:0] word_t;
  typedef logic [ADDR_WIDTH_DEFAULT-1:0] address_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_ACCESS,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_arb_state_e;

  typedef struct packed {
    logic     we;
    address_t addr;
    word_t    wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: one-hot grant from the valid bits, remembering the last winner.
module rr_grant2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reqValid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       lastGrant
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (reqValid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Starting at 1 lets requester 0 win the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant <= 1'b1;
    end else if (update && (|grant)) begin
      lastGrant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two cores' accesses onto one single-port data memory, round-robin on contention.
// Optional DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter
  import types_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int MEM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][XLEN-1:0]       req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [1:0][XLEN-1:0]       rsp_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  input  logic [XLEN-1:0]            mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [1:0][31:0]           grant_cnt,
  output logic [31:0]                conflict_cnt
`endif
);

  dmem_arb_state_e state, stateNext;
  dmem_req_t       reqReg, selReq;
  logic [3:0]      waitCnt;
  logic [1:0]      grant;
  logic            lastGrant;
  logic            accept;
  logic            selIdx;

  rr_grant2 uGrant (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (req_valid),
    .update    (accept),
    .grant     (grant),
    .lastGrant (lastGrant)
  );

  assign accept    = (state == DMEM_IDLE) && (|req_valid);
  assign req_ready = (state == DMEM_IDLE) ? grant : 2'b00;
  assign mem_addr  = reqReg.addr;
  assign mem_wdata = reqReg.wdata;

  always_comb begin
    selIdx       = grant[1];
    selReq.we    = req_we[selIdx];
    selReq.addr  = req_addr[selIdx];
    selReq.wdata = req_wdata[selIdx];
  end

  always_comb begin
    stateNext = state;
    case (state)
      DMEM_IDLE:   if (|req_valid) stateNext = DMEM_ACCESS;
      DMEM_ACCESS: stateNext = DMEM_WAIT;
      DMEM_WAIT:   if (waitCnt == 4'd1) stateNext = DMEM_RESP;
      DMEM_RESP:   stateNext = DMEM_IDLE;
      default:     stateNext = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DMEM_IDLE;
    else       state <= stateNext;
  end

  // mem_en is raised on the accept edge so the strobe lines up with the ACCESS cycle;
  // lastGrant already names the owner of the transaction after that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqReg    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      waitCnt   <= 4'd0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        DMEM_IDLE: begin
          if (accept) begin
            reqReg <= selReq;
            mem_en <= 1'b1;
            mem_we <= selReq.we;
          end
        end
        DMEM_ACCESS: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          waitCnt <= 4'(MEM_LATENCY);
        end
        DMEM_WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            rsp_valid[lastGrant] <= 1'b1;
            if (!reqReg.we) rsp_rdata[lastGrant] <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // A conflict is any cycle where a valid request is left waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DMEM_REQ; i++) begin
        if (accept && grant[i] && (grant_cnt[i] != 32'hFFFF_FFFF))
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if ((|(req_valid & ~req_ready)) && (conflict_cnt != 32'hFFFF_FFFF))
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic             mem_en, mem_we;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [1:0][31:0] grant_cnt;
  logic [31:0]      conflict_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] initVal(input logic [7:0] a);
    if (a == 8'h20) return 32'h1234_5678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Memory with a read latency of LAT cycles; garbage on the bus when no read is in flight.
  logic [31:0] memArr [256];
  bit [255:0]  memWritten;
  logic [31:0] rdPipe [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      memArr[mem_addr[7:0]]     <= mem_wdata;
      memWritten[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we)
      rdPipe[0] <= memWritten[mem_addr[7:0]] ? memArr[mem_addr[7:0]] : initVal(mem_addr[7:0]);
    else
      rdPipe[0] <= 32'hBADC_0FFE;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign mem_rdata = rdPipe[LAT-1];

  // Reference model: memory contents, arbitration history, response data, counters.
  logic [31:0] refMem [256];
  bit [255:0]  refWritten;
  int          lastWin;
  logic [31:0] shadow [2];
  int          expGrants [2];
  int          expConflicts;

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refWritten[a[7:0]] ? refMem[a[7:0]] : initVal(a[7:0]);
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [31:0] d);
    refMem[a[7:0]]     = d;
    refWritten[a[7:0]] = 1'b1;
  endtask

  task automatic modelReset();
    lastWin = 1;
    shadow[0] = '0; shadow[1] = '0;
    expGrants[0] = 0; expGrants[1] = 0;
    expConflicts = 0;
  endtask

  task automatic applyReset();
    req_valid = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_en, mem_we} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {req_ready, rsp_valid, mem_en, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr %h wdata %h rdata %h, expected zeros", mem_addr, mem_wdata, rsp_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if ({grant_cnt, conflict_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got %h %h, expected zeros", grant_cnt, conflict_cnt);
    end
`endif
  endtask

  // One isolated transaction from requester idx, checking the full cycle-by-cycle timeline.
  task automatic test_single(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [1:0]  oh, expReady, expRsp;
    logic [31:0] expData;
    oh = 2'b00; oh[idx] = 1'b1;
    req_valid = oh; req_we[idx] = we; req_addr[idx] = addr; req_wdata[idx] = wdata;
    expData = refRead(addr);
    if (we) refWrite(addr, wdata);
    lastWin = idx;
    expGrants[idx]++;
    for (int c = 0; c <= 2 + LAT; c++) begin
      @(negedge clk);
      expReady = (c == 0) ? oh : 2'b00;
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL single_ready c%0d: got %b, expected %b", c, req_ready, expReady);
      end
      if (c == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, we, addr} || (we && mem_wdata !== wdata)) begin
          errors++;
          $display("[TB] FAIL single_mem: got en %b we %b addr %h wdata %h, expected 1 %b %h %h",
                   mem_en, mem_we, mem_addr, mem_wdata, we, addr, wdata);
        end
      end
      if (c == 2) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b00, addr}) begin
          errors++;
          $display("[TB] FAIL single_wait: got en %b we %b addr %h, expected 0 0 %h", mem_en, mem_we, mem_addr, addr);
        end
      end
      expRsp = (c == 2 + LAT) ? oh : 2'b00;
      if (c == 2 + LAT && !we) shadow[idx] = expData;
      checks++;
      if (rsp_valid !== expRsp) begin
        errors++;
        $display("[TB] FAIL single_rsp c%0d: got %b, expected %b", c, rsp_valid, expRsp);
      end
      if (c == 2 + LAT) begin
        checks++;
        if (rsp_rdata !== {shadow[1], shadow[0]}) begin
          errors++;
          $display("[TB] FAIL single_rdata: got %h, expected %h", rsp_rdata, {shadow[1], shadow[0]});
        end
      end
      @(posedge clk); #1;
      if (c == 0) req_valid = 2'b00;
    end
  endtask

  // Both requesters raise a request in the same cycle right after reset.
  task automatic test_contention(input logic we1, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1);
    logic [1:0]  weV, expReady, expRsp;
    logic [31:0] addrV [2], dataV [2], expData [2];
    int          acceptAt [2];
    int          first;
    applyReset();
    weV = {we1, 1'b0};
    addrV[0] = a0; addrV[1] = a1; dataV[0] = $urandom; dataV[1] = wd1;
    req_valid = 2'b11; req_we = weV;
    req_addr[0] = a0; req_addr[1] = a1; req_wdata[0] = dataV[0]; req_wdata[1] = wd1;
    first = 1 - lastWin;
    acceptAt[first] = 0; acceptAt[1-first] = 3 + LAT;
    for (int c = 0; c <= 5 + 2*LAT; c++) begin
      expReady = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (c == acceptAt[r]) begin
          expReady[r] = 1'b1;
          expData[r] = refRead(addrV[r]);
          if (weV[r]) refWrite(addrV[r], dataV[r]);
          lastWin = r;
          expGrants[r]++;
        end
      end
      if (|(req_valid & ~expReady)) expConflicts++;
      @(negedge clk);
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL tie_ready c%0d: got %b, expected %b", c, req_ready, expReady);
      end
      expRsp = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (c == acceptAt[r] + 2 + LAT) begin
          expRsp[r] = 1'b1;
          if (!weV[r]) shadow[r] = expData[r];
        end
      end
      checks++;
      if ({rsp_valid, rsp_rdata} !== {expRsp, shadow[1], shadow[0]}) begin
        errors++;
        $display("[TB] FAIL tie_rsp c%0d: got %b %h, expected %b %h", c, rsp_valid, rsp_rdata, expRsp, {shadow[1], shadow[0]});
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~expReady;
    end
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if ({grant_cnt, conflict_cnt} !== {32'(expGrants[1]), 32'(expGrants[0]), 32'(expConflicts)}) begin
      errors++;
      $display("[TB] FAIL tie_stats: got %h %h, expected %0d %0d %0d", grant_cnt, conflict_cnt, expGrants[1], expGrants[0], expConflicts);
    end
`endif
  endtask

  // Both requesters keep asking until each has been served four times.
  task automatic test_back_to_back();
    logic [1:0] expReady, expRsp;
    logic [31:0] rdExp [2];
    int nextFree, w;
    int served [2];
    int rspAt [2];
    int seq [$];
    applyReset();
    nextFree = 0; served[0] = 0; served[1] = 0; rspAt[0] = -100; rspAt[1] = -100;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    for (int c = 0; c < 8 * (3 + LAT); c++) begin
      expReady = 2'b00;
      if (req_valid != 2'b00 && c >= nextFree) begin
        w = (req_valid == 2'b11) ? 1 - lastWin : (req_valid[1] ? 1 : 0);
        expReady[w] = 1'b1;
        lastWin = w; nextFree = c + 3 + LAT; rspAt[w] = c + 2 + LAT;
        rdExp[w] = refRead(req_addr[w]);
        served[w]++; expGrants[w]++;
      end
      if (|(req_valid & ~expReady)) expConflicts++;
      @(negedge clk);
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL b2b_ready c%0d: got %b, expected %b", c, req_ready, expReady);
      end
      if (req_ready == 2'b01) seq.push_back(0);
      if (req_ready == 2'b10) seq.push_back(1);
      expRsp = 2'b00;
      for (int r = 0; r < 2; r++) if (c == rspAt[r]) begin expRsp[r] = 1'b1; shadow[r] = rdExp[r]; end
      checks++;
      if ({rsp_valid, rsp_rdata} !== {expRsp, shadow[1], shadow[0]}) begin
        errors++;
        $display("[TB] FAIL b2b_rsp c%0d: got %b %h, expected %b %h", c, rsp_valid, rsp_rdata, expRsp, {shadow[1], shadow[0]});
      end
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) if (expReady[r] && served[r] == 4) req_valid[r] = 1'b0;
    end
    checks++;
    if (seq.size() != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d grants, expected 8", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != k % 2) begin
        errors++;
        $display("[TB] FAIL b2b_order #%0d: got %0d, expected %0d", k, seq[k], k % 2);
      end
    end
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if ({grant_cnt, conflict_cnt} !== {32'd4, 32'd4, 32'(expConflicts)}) begin
      errors++;
      $display("[TB] FAIL b2b_stats: got %h %h, expected 4 4 %0d", grant_cnt, conflict_cnt, expConflicts);
    end
`endif
  endtask

  // Reset lands while a read sits in WAIT; the read must vanish without a response.
  task automatic test_reset_during_wait();
    test_single(0, 1'b0, 32'h20, 32'h0);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rstwait_accept: got %b, expected 01", req_ready);
    end
    @(posedge clk); #1; req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    modelReset();
    checks++;
    if ({rsp_valid, mem_en, rsp_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL rstwait_async: got %b %b %h, expected zeros", rsp_valid, mem_en, rsp_rdata);
    end
    @(posedge clk); #1; reset = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rstwait_dropped c%0d: got %b, expected 00", c, rsp_valid);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b11; req_addr[1] = 32'h20;
    @(negedge clk);
    checks++;
    if (req_ready !== ((lastWin == 1) ? 2'b01 : 2'b10)) begin
      errors++;
      $display("[TB] FAIL rstwait_tie: got %b, expected 01", req_ready);
    end
    @(posedge clk); #1;
  endtask

  // Random traffic from both requesters, checked every cycle against the transaction model.
  task automatic test_random();
    logic [1:0]  pend, expReady, expRsp;
    logic [31:0] rspData [2];
    bit          rspRead [2];
    int          rspAt [2];
    int          nextFree, w, c;
    applyReset();
    pend = 2'b00; nextFree = 0; rspAt[0] = -100; rspAt[1] = -100;
    for (c = 0; c < 400; c++) begin
      if (c >= 300 && pend == 2'b00 && c > rspAt[0] && c > rspAt[1]) break;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < 300 && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          req_we[i] = 1'($urandom_range(0, 1));
          req_addr[i] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          req_wdata[i] = $urandom;
        end
      end
      req_valid = pend;
      expReady = 2'b00;
      if (pend != 2'b00 && c >= nextFree) begin
        w = (pend == 2'b11) ? 1 - lastWin : (pend[1] ? 1 : 0);
        expReady[w] = 1'b1;
        lastWin = w; nextFree = c + 3 + LAT; rspAt[w] = c + 2 + LAT;
        rspData[w] = refRead(req_addr[w]); rspRead[w] = !req_we[w];
        if (req_we[w]) refWrite(req_addr[w], req_wdata[w]);
        expGrants[w]++;
      end
      if (|(pend & ~expReady)) expConflicts++;
      @(negedge clk);
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL rand_ready c%0d: got %b, expected %b", c, req_ready, expReady);
      end
      expRsp = 2'b00;
      for (int r = 0; r < 2; r++) if (c == rspAt[r]) begin
        expRsp[r] = 1'b1;
        if (rspRead[r]) shadow[r] = rspData[r];
      end
      checks++;
      if ({rsp_valid, rsp_rdata} !== {expRsp, shadow[1], shadow[0]}) begin
        errors++;
        $display("[TB] FAIL rand_rsp c%0d: got %b %h, expected %b %h", c, rsp_valid, rsp_rdata, expRsp, {shadow[1], shadow[0]});
      end
      pend = pend & ~expReady;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    checks++;
    if (c >= 400) begin
      errors++;
      $display("[TB] FAIL rand_drain: got still busy at cycle %0d, expected idle", c);
    end
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if ({grant_cnt, conflict_cnt} !== {32'(expGrants[1]), 32'(expGrants[0]), 32'(expConflicts)}) begin
      errors++;
      $display("[TB] FAIL rand_stats: got %h %h, expected %0d %0d %0d", grant_cnt, conflict_cnt, expGrants[1], expGrants[0], expConflicts);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    test_contention(1'b0, 32'h10, 32'h20, 32'h0);
    test_back_to_back();
    test_contention(1'b1, 32'h8, 32'h8, 32'h55);
    test_single(0, 1'b0, 32'h8, 32'h0);
    test_reset_during_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
